// File: rtl/audio_pkg.sv
// Shared types and clip table for the audio PWM player.
// Clip lengths are in samples; base addresses wrap modulo the ROM address space.
package audio_pkg;

    localparam int CLIP_AW = 16;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, DONE} state_e;

    typedef struct packed {
        logic [CLIP_AW-1:0] base;
        logic [CLIP_AW-1:0] len;
    } clip_t;

    typedef clip_t [3:1] clip_tab_t;

    localparam logic [1:0] SEL_NONE = 2'b00;

    localparam clip_t CLIP_1 = '{base: 16'h0010, len: 16'd4};
    localparam clip_t CLIP_2 = '{base: 16'h0200, len: 16'd3};
    localparam clip_t CLIP_3 = '{base: 16'hFFFE, len: 16'd4};

    localparam clip_tab_t CLIP_TABLE = {CLIP_3, CLIP_2, CLIP_1};

    function automatic clip_t clip_lookup(input clip_tab_t tab, input logic [1:0] sel);
        clip_t c;
        c = '0;
        case (sel)
            2'b01:   c = tab[1];
            2'b10:   c = tab[2];
            2'b11:   c = tab[3];
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/audio_pwm_gen.sv
// Free-running PWM: duty reloads only when the period counter wraps, so edges never glitch.
// Output is combinational from registered pc/duty; no backpressure.
module audio_pwm_gen #(
    parameter int SAMPLE_W = 8
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_en,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic                o_pwm
);

    logic [SAMPLE_W-1:0] r_pc;
    logic [SAMPLE_W-1:0] r_duty;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc   <= '0;
            r_duty <= '0;
        end else begin
            r_pc <= r_pc + SAMPLE_W'(1);
            if (r_pc == '1) begin
                r_duty <= i_sample;
            end
        end
    end

    assign o_pwm = i_en & (r_pc < r_duty);

endmodule

// File: rtl/audio_pwm_player.sv
// Streams the selected clip from a 1-clk-latency sample ROM into a PWM; start-to-sample 2 clk,
// no backpressure. Define AUDIO_PWM_LOOP_EN to make clip 1 loop until aborted.
module audio_pwm_player
    import audio_pkg::*;
#(
    parameter int        CLK_HZ    = 50_000_000,
    parameter int        SAMPLE_HZ = 16_000,
    parameter int        SAMPLE_W  = 8,
    parameter int        ADDR_W    = 16,
    parameter clip_tab_t CLIPS     = CLIP_TABLE
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_en,
    input  logic [1:0]          i_effective_select,
    output logic [ADDR_W-1:0]   o_rom_addr,
    input  logic [SAMPLE_W-1:0] i_rom_data,
    output logic                o_pwm_out,
    output logic                o_busy,
    output logic                o_playback_complete
);

    localparam int CLK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int TICK_W  = $clog2(CLK_DIV);

    if (CLK_DIV < (1 << SAMPLE_W)) begin : g_cfg_check
        $error("CLK_DIV must be at least 2**SAMPLE_W");
    end

`ifdef AUDIO_PWM_LOOP_EN
    localparam bit LOOP_CLIP1 = 1'b1;
`else
    localparam bit LOOP_CLIP1 = 1'b0;
`endif

    state_e              r_state, w_state_nxt;
    logic [1:0]          r_sel;
    logic [ADDR_W-1:0]   r_base, r_len, r_idx, r_rom_addr;
    logic [TICK_W-1:0]   r_tick;
    logic                r_armed;
    logic [SAMPLE_W-1:0] r_next_sample;

    clip_t               w_clip;
    logic [ADDR_W-1:0]   w_clip_base, w_clip_len, w_idx_nxt;
    logic                w_start, w_tick, w_last, w_loop, w_rearm;

    assign w_clip      = clip_lookup(CLIPS, i_effective_select);
    assign w_clip_base = ADDR_W'(w_clip.base);
    assign w_clip_len  = ADDR_W'(w_clip.len);
    assign w_start     = i_en && (i_effective_select != SEL_NONE) && r_armed;
    assign w_tick      = (r_tick == TICK_W'(CLK_DIV - 1));
    assign w_last      = (r_idx == r_len - ADDR_W'(1));
    assign w_loop      = LOOP_CLIP1 && (r_sel == 2'b01);
    assign w_idx_nxt   = w_last ? '0 : r_idx + ADDR_W'(1);
    // Dropping en or moving to any other selection both stops playback and re-arms a start.
    assign w_rearm     = !i_en || (i_effective_select != r_sel);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = (w_clip_len == '0) ? DONE : FETCH;
            FETCH:   w_state_nxt = WAIT;
            WAIT:    w_state_nxt = PLAY;
            PLAY:    if (w_tick) w_state_nxt = (w_last && !w_loop) ? DONE : FETCH;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (r_state != IDLE && w_rearm) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_sel         <= SEL_NONE;
            r_base        <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_tick        <= '0;
            r_armed       <= 1'b1;
            r_rom_addr    <= '0;
            r_next_sample <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= (r_state == IDLE || w_tick) ? '0 : r_tick + TICK_W'(1);
            if (w_rearm) begin
                r_armed <= 1'b1;
            end else if (r_state == DONE) begin
                r_armed <= 1'b0;
            end
            if (r_state == IDLE && w_start) begin
                r_sel  <= i_effective_select;
                r_base <= w_clip_base;
                r_len  <= w_clip_len;
                r_idx  <= '0;
            end
            if (r_state == PLAY && w_state_nxt == FETCH) begin
                r_idx <= w_idx_nxt;
            end
            // Address is presented during FETCH so the ROM word is ready in WAIT.
            if (w_state_nxt == FETCH) begin
                r_rom_addr <= (r_state == IDLE) ? w_clip_base : r_base + w_idx_nxt;
            end
            if (r_state == WAIT) begin
                r_next_sample <= i_rom_data;
            end
        end
    end

    assign o_rom_addr          = r_rom_addr;
    assign o_busy              = (r_state != IDLE);
    assign o_playback_complete = (r_state == DONE);

    audio_pwm_gen #(
        .SAMPLE_W (SAMPLE_W)
    ) u_pwm (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (o_busy),
        .i_sample  (r_next_sample),
        .o_pwm     (o_pwm_out)
    );

endmodule

// File: tb/tb_audio_pwm_player.sv
// Bench for audio_pwm_player with CLK_DIV = 256 and a 1-clk-latency ROM model.
// Expected timing is derived from clip start: sample i fetched 256*i cycles after start.
module tb_audio_pwm_player;
    import audio_pkg::*;

    localparam int DIV = 256;
    localparam clip_t     Z_CLIP1 = '{base: 16'h0010, len: 16'd0};
    localparam clip_tab_t Z_TABLE = {CLIP_3, CLIP_2, Z_CLIP1};

    int unsigned c_base [1:3] = '{32'h0010, 32'h0200, 32'hFFFE};
    int          c_len  [1:3] = '{4, 3, 4};

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        en = 1'b0, en_z = 1'b0;
    logic [1:0]  sel = 2'b00, sel_z = 2'b00;
    logic [15:0] rom_addr, rom_addr_z;
    logic [7:0]  rom_data, rom_data_z;
    logic        pwm, busy, done, pwm_z, busy_z, done_z;
    logic [7:0]  mem [0:65535];
    logic [7:0]  m_pc;
    int          checks = 0, failures = 0, cyc = 0;
    int          pulse_q[$];

    audio_pwm_player #(.CLK_HZ(1024), .SAMPLE_HZ(4), .SAMPLE_W(8), .ADDR_W(16)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_effective_select(sel),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_pwm_out(pwm),
        .o_busy(busy), .o_playback_complete(done));

    audio_pwm_player #(.CLK_HZ(1024), .SAMPLE_HZ(4), .SAMPLE_W(8), .ADDR_W(16),
                       .CLIPS(Z_TABLE)) u_dut_z (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en_z), .i_effective_select(sel_z),
        .o_rom_addr(rom_addr_z), .i_rom_data(rom_data_z), .o_pwm_out(pwm_z),
        .o_busy(busy_z), .o_playback_complete(done_z));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data   <= mem[rom_addr];
        rom_data_z <= mem[rom_addr_z];
        cyc        <= cyc + 1;
    end

    // Reference PWM period counter: free-running from reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_pc <= 8'd0;
        else        m_pc <= m_pc + 8'd1;
    end

    always @(negedge clk) if (done === 1'b1) pulse_q.push_back(cyc);

    // Start so the first sample's duty loads exactly when a PWM period begins (pc = 253 at n=0).
    task automatic start_clip(input logic [1:0] s, output int t0);
        int guard;
        guard = 0;
        while (m_pc != 8'd252 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        en  = 1'b1;
        sel = s;
        @(negedge clk);
        t0 = cyc;
    endtask

    // Called at n=0 of a play of clip s that should end naturally.
    task automatic observe(input logic [1:0] s, input int t0, input bit chk_pwm);
        int len, busy_err;
        int hi [0:3];
        len = c_len[s];
        busy_err = 0;
        for (int j = 0; j < 4; j++) hi[j] = 0;
        for (int n = 0; n <= DIV*len + 1; n++) begin
            if (n > 0) @(negedge clk);
            if (n % DIV == 0 && n / DIV < len) begin
                checks++;
                if (rom_addr !== 16'(c_base[s] + n / DIV)) begin
                    failures++;
                    $display("FAIL rom_addr clip%0d sample%0d: got %h want %h", s, n / DIV,
                             rom_addr, 16'(c_base[s] + n / DIV));
                end
            end
            if (busy !== (n <= DIV*len)) busy_err++;
            if (n >= 3 && pwm === 1'b1) hi[(n - 3) / DIV]++;
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL busy_window clip%0d: %0d bad cycles, want 0", s, busy_err);
        end
        checks++;
        if (pulse_q.size() != 1) begin
            failures++;
            $display("FAIL complete_count clip%0d: got %0d pulses want 1", s, pulse_q.size());
        end else if (pulse_q[0] != t0 + DIV*len) begin
            failures++;
            $display("FAIL complete_time clip%0d: got cycle %0d want %0d", s, pulse_q[0], t0 + DIV*len);
        end
        if (chk_pwm) begin
            for (int j = 0; j < len; j++) begin
                int sj, exp_hi;
                sj = mem[16'(c_base[s] + j)];
                exp_hi = 0;
                // Period j starts at n=3+256j; cycles after busy drops never count.
                for (int k = 0; k < DIV; k++) if (k < sj && 3 + DIV*j + k <= DIV*len) exp_hi++;
                checks++;
                if (hi[j] != exp_hi) begin
                    failures++;
                    $display("FAIL pwm_high period%0d: got %0d want %0d", j, hi[j], exp_hi);
                end
            end
        end
    endtask

    task automatic run_clip(input logic [1:0] s, input bit chk_pwm);
        int t0;
        pulse_q.delete();
        start_clip(s, t0);
        observe(s, t0, chk_pwm);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (rom_addr !== 16'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", rom_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (pwm !== 1'b0) begin failures++; $display("FAIL reset_pwm: got %b want 0", pwm); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_len0;
        logic [15:0] a0;
        int bad;
        a0 = rom_addr_z;
        en_z = 1'b1; sel_z = 2'b01;
        @(negedge clk);
        checks++;
        if (done_z !== 1'b1 || busy_z !== 1'b1) begin
            failures++; $display("FAIL len0_pulse: done=%b busy=%b want 1 1", done_z, busy_z);
        end
        @(negedge clk);
        checks++;
        if (done_z !== 1'b0 || busy_z !== 1'b0) begin
            failures++; $display("FAIL len0_end: done=%b busy=%b want 0 0", done_z, busy_z);
        end
        bad = 0;
        repeat (4) begin @(negedge clk); if (done_z !== 1'b0 || busy_z !== 1'b0) bad++; end
        checks++; if (bad != 0) begin failures++; $display("FAIL len0_rearm: %0d active cycles want 0", bad); end
        checks++; if (rom_addr_z !== a0) begin failures++; $display("FAIL len0_addr: got %h want %h", rom_addr_z, a0); end
        en_z = 1'b0; sel_z = 2'b00;
    endtask

    task automatic test_clip1;
        mem[16'h0010] = 8'd0;   mem[16'h0011] = 8'd64;
        mem[16'h0012] = 8'd128; mem[16'h0013] = 8'd255;
        run_clip(2'b01, 1'b1);
        en = 1'b0; sel = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_loop;
        int t0, busy_err;
        pulse_q.delete();
        start_clip(2'b01, t0);
        busy_err = 0;
        for (int n = 0; n < 3*4*DIV; n++) begin
            if (n > 0) @(negedge clk);
            if (n % DIV == 0) begin
                checks++;
                if (rom_addr !== 16'(c_base[1] + (n / DIV) % 4)) begin
                    failures++;
                    $display("FAIL loop_addr step%0d: got %h want %h", n / DIV, rom_addr, 16'(c_base[1] + (n / DIV) % 4));
                end
            end
            if (busy !== 1'b1) busy_err++;
        end
        checks++; if (busy_err != 0) begin failures++; $display("FAIL loop_busy: %0d idle cycles want 0", busy_err); end
        checks++; if (pulse_q.size() != 0) begin failures++; $display("FAIL loop_pulses: got %0d want 0", pulse_q.size()); end
        en = 1'b0; sel = 2'b00;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL loop_stop: busy=%b want 0", busy); end
    endtask

    task automatic test_no_replay;
        int bad;
        run_clip(2'b10, 1'b0);
        bad = 0;
        repeat (5) begin @(negedge clk); if (busy !== 1'b0 || done !== 1'b0) bad++; end
        checks++; if (bad != 0) begin failures++; $display("FAIL no_replay: %0d active cycles want 0", bad); end
        en = 1'b0;
        @(negedge clk);
        run_clip(2'b10, 1'b0);
        en = 1'b0; sel = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_abort;
        for (int it = 0; it < 2; it++) begin
            int t0, r;
            logic [1:0] s;
            // Second pass lands on clip 2's final tick: abort must beat DONE.
            s = (it == 0) ? 2'($urandom_range(1, 3)) : 2'b10;
            r = (it == 0) ? $urandom_range(0, DIV - 2) : DIV - 1;
            pulse_q.delete();
            start_clip(s, t0);
            repeat (2*DIV + r) @(negedge clk);
            if (it == 0) en = 1'b0;
            else         sel = SEL_NONE;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || pwm !== 1'b0) begin
                failures++; $display("FAIL abort%0d_idle: busy=%b pwm=%b want 0 0", it, busy, pwm);
            end
            repeat (3*DIV) @(negedge clk);
            checks++;
            if (pulse_q.size() != 0) begin
                failures++; $display("FAIL abort%0d_pulse: got %0d pulses want 0", it, pulse_q.size());
            end
            en = 1'b0; sel = 2'b00;
            @(negedge clk);
        end
    endtask

    task automatic test_retarget;
        int t0, r;
        pulse_q.delete();
        start_clip(2'b10, t0);
        r = $urandom_range(0, DIV - 1);
        repeat (DIV + r) @(negedge clk);
        sel = 2'b11;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL retarget_idle: busy=%b want 0", busy); end
        @(negedge clk);
        observe(2'b11, cyc, 1'b0);
        en = 1'b0; sel = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int t0;
        pulse_q.delete();
        start_clip(2'($urandom_range(1, 3)), t0);
        repeat (DIV + $urandom_range(0, DIV - 1)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rom_addr !== 16'h0 || busy !== 1'b0 || pwm !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: addr=%h busy=%b pwm=%b done=%b want all 0", rom_addr, busy, pwm, done);
        end
        en = 1'b0; sel = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2*DIV) @(negedge clk);
        checks++;
        if (pulse_q.size() != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_after: pulses=%0d busy=%b want 0 0", pulse_q.size(), busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_len0();
`ifdef AUDIO_PWM_LOOP_EN
        test_loop();
`else
        test_clip1();
`endif
        test_no_replay();
        test_abort();
        test_retarget();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
